// File: rtl/fir_interp_if.sv
// FIFO-side signal bundle of the fir_interp polyphase interpolator.
// master: the filter (pops input FIFO, pushes output FIFO); slave: the FIFO side.
interface fir_interp_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_rd_en;
  logic                         x_empty;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         y_wr_en;
  logic                         y_out_full;

  // Handshake: a word moves from the input FIFO when x_rd_en=1 at a rising edge
  // (x_rd_en only rises while x_empty=0); a word enters the output FIFO when
  // y_wr_en=1 at a rising edge, and y_wr_en is only raised while y_out_full=0.
  modport master (
    input  x_in, x_empty, y_out_full,
    output x_rd_en, y_out, y_wr_en
  );

  modport slave (
    output x_in, x_empty, y_out_full,
    input  x_rd_en, y_out, y_wr_en
  );
endinterface

// File: rtl/fir_interp.sv
// Polyphase FIR interpolator: one MAC per cycle, INTERPOLATION outputs per input.
// Optional FIR_INTERP_GAIN_EN: scale each result by INTERPOLATION (left shift, wrapping).
module fir_interp #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAPS          = 32,
  parameter int INTERPOLATION = 4,
  parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = {
    -32'sd3,   -32'sd11,  -32'sd18,  -32'sd11,  32'sd16,   32'sd50,   32'sd67,   32'sd36,
    -32'sd46,  -32'sd141, -32'sd182, -32'sd99,  32'sd133,  32'sd467,  32'sd795,  32'sd998,
    32'sd998,  32'sd795,  32'sd467,  32'sd133,  -32'sd99,  -32'sd182, -32'sd141, -32'sd46,
    32'sd36,   32'sd67,   32'sd50,   32'sd16,   -32'sd11,  -32'sd18,  -32'sd11,  -32'sd3
  }
) (
  input  logic       clock,
  input  logic       reset,
  fir_interp_if.master io,
  output logic [1:0] state_dbg
);

  localparam int PHASE_TAPS = TAPS / INTERPOLATION;
  localparam int KW = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
  localparam int PW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] dl [TAPS];
  logic signed [DATA_WIDTH-1:0] acc;
  logic        [PW-1:0]         phase;
  logic        [KW-1:0]         tap;
  logic signed [DATA_WIDTH-1:0] y_out_q;
  logic                         y_wr_q;

  logic        [IW-1:0]         coef_idx;
  logic signed [DATA_WIDTH-1:0] coef_sel;
  logic signed [DATA_WIDTH-1:0] tap_x;
  logic signed [DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] prod_adj;
  logic signed [DATA_WIDTH-1:0] deq;
  logic signed [DATA_WIDTH-1:0] result;

  // Phase p uses every INTERPOLATION-th coefficient starting at p.
  assign coef_idx = IW'(tap) * IW'(INTERPOLATION) + IW'(phase);
  assign coef_sel = $signed(COEFF[coef_idx*DATA_WIDTH +: DATA_WIDTH]);
  assign tap_x    = dl[IW'(tap)];
  assign prod     = coef_sel * tap_x;

  // Q10 dequantise rounding toward zero: bias negatives by 1023 before the arithmetic shift.
  assign prod_adj = prod + (prod[DATA_WIDTH-1] ? DATA_WIDTH'(1023) : '0);
  assign deq      = prod_adj >>> 10;

`ifdef FIR_INTERP_GAIN_EN
  localparam int GAIN_SH = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 0;
  assign result = acc <<< GAIN_SH;
`else
  assign result = acc;
`endif

  // Pop is combinational so the FIFO word is consumed in the same cycle it is seen.
  assign io.x_rd_en = (state == S_READ) && !io.x_empty && !reset;
  assign io.y_out   = y_out_q;
  assign io.y_wr_en = y_wr_q;
  assign state_dbg  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_READ;
      acc     <= '0;
      phase   <= '0;
      tap     <= '0;
      y_out_q <= '0;
      y_wr_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end else begin
      y_wr_q <= 1'b0;
      case (state)
        S_READ: begin
          if (!io.x_empty) begin
            for (int i = TAPS - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= io.x_in;
            acc   <= '0;
            phase <= '0;
            tap   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + deq;
          if (tap == KW'(PHASE_TAPS - 1)) begin
            tap   <= '0;
            state <= S_WRITE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_WRITE: begin
          // While the output FIFO is full everything holds, including y_out.
          if (!io.y_out_full) begin
            y_out_q <= result;
            y_wr_q  <= 1'b1;
            if (phase == PW'(INTERPOLATION - 1)) begin
              state <= S_READ;
            end else begin
              phase <= phase + 1'b1;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Self-checking bench for fir_interp: two instances (impulse and signed coefficient sets)
// fed from one input FIFO model, checked against a reference scoreboard.
module tb_fir_interp;

  localparam int DW     = 32;
  localparam int TAPS   = 32;
  localparam int INTERP = 4;
  localparam int PH     = TAPS / INTERP;
  localparam int TMO    = 3000;
`ifdef FIR_INTERP_GAIN_EN
  localparam int GAIN = INTERP;
`else
  localparam int GAIN = 1;
`endif

  function automatic logic [TAPS*DW-1:0] make_coef_a();
    logic [TAPS*DW-1:0] v;
    v = '0;
    for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'((i + 1) * 1024);
    return v;
  endfunction

  function automatic logic [TAPS*DW-1:0] make_coef_b();
    logic [TAPS*DW-1:0] v;
    v = '0;
    for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'(100 + i);
    v[0 +: DW]  = DW'(-3);
    v[DW +: DW] = DW'(-1);
    return v;
  endfunction

  localparam logic [TAPS*DW-1:0] COEF_A = make_coef_a();
  localparam logic [TAPS*DW-1:0] COEF_B = make_coef_b();

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  fir_interp_if #(.DATA_WIDTH(DW)) if_a ();
  fir_interp_if #(.DATA_WIDTH(DW)) if_b ();
  logic [1:0] st_a, st_b;

  logic [DW-1:0] drv_x = '0;
  logic          drv_empty = 1'b1;
  logic          drv_full = 1'b0;
  logic          hold_empty = 1'b0;

  assign if_a.x_in       = drv_x;
  assign if_a.x_empty    = drv_empty;
  assign if_a.y_out_full = drv_full;
  assign if_b.x_in       = drv_x;
  assign if_b.x_empty    = drv_empty;
  assign if_b.y_out_full = drv_full;

  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERPOLATION(INTERP), .COEFF(COEF_A)) dut_a (
    .clock(clk), .reset(rst), .io(if_a.master), .state_dbg(st_a)
  );
  fir_interp #(.DATA_WIDTH(DW), .TAPS(TAPS), .INTERPOLATION(INTERP), .COEFF(COEF_B)) dut_b (
    .clock(clk), .reset(rst), .io(if_b.master), .state_dbg(st_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0]        in_q [$];
  logic [DW-1:0]        exp_a [$];
  logic [DW-1:0]        exp_b [$];
  logic [DW-1:0]        got_a [$];
  logic [DW-1:0]        got_b [$];
  int                   rd_cyc [$];
  int                   wr_cyc_a [$];
  logic signed [DW-1:0] dl_m [TAPS];
  logic                 prev_wr_a = 1'b0;
  logic                 prev_wr_b = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d", tag, $signed(obs), obs, $signed(exp));
    end
  endtask

  // Reference: per-product truncating division, 32-bit wrapping sums.
  function automatic logic [DW-1:0] model_phase(input logic [TAPS*DW-1:0] cf, input int p);
    logic signed [DW-1:0] c, prod, sum;
    sum = '0;
    for (int k = 0; k < PH; k++) begin
      c    = cf[(k*INTERP + p)*DW +: DW];
      prod = c * dl_m[k];
      sum  = sum + prod / 32'sd1024;
    end
    return sum * GAIN;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  // ---------------- FIFO driver + output monitor ----------------
  always begin
    @(negedge clk);
    cyc++;
    if (prev_wr_a) chk("wr_single_pulse_a", if_a.y_wr_en, 1'b0);
    if (prev_wr_b) chk("wr_single_pulse_b", if_b.y_wr_en, 1'b0);
    prev_wr_a = if_a.y_wr_en;
    prev_wr_b = if_b.y_wr_en;
    if (rst) begin
      chk("reset_y_wr_en", if_a.y_wr_en, 1'b0);
      chk("reset_y_out", if_a.y_out, '0);
    end
    if (if_a.y_wr_en) begin
      if (exp_a.size() == 0) chk("unexpected_push_a", if_a.y_wr_en, 1'b0);
      else chk("y_out_a", if_a.y_out, exp_a.pop_front());
      got_a.push_back(if_a.y_out);
      wr_cyc_a.push_back(cyc);
    end
    if (if_b.y_wr_en) begin
      if (exp_b.size() == 0) chk("unexpected_push_b", if_b.y_wr_en, 1'b0);
      else chk("y_out_b", if_b.y_out, exp_b.pop_front());
      got_b.push_back(if_b.y_out);
    end
    drv_x     = (in_q.size() > 0) ? in_q[0] : '0;
    drv_empty = hold_empty || (in_q.size() == 0);
    #4;
    if (st_a != 2'd0) chk("rd_outside_read_a", if_a.x_rd_en, 1'b0);
    if (st_b != 2'd0) chk("rd_outside_read_b", if_b.x_rd_en, 1'b0);
    if (if_a.x_rd_en) begin
      for (int i = TAPS - 1; i > 0; i--) dl_m[i] = dl_m[i-1];
      dl_m[0] = in_q.pop_front();
      for (int p = 0; p < INTERP; p++) begin
        exp_a.push_back(model_phase(COEF_A, p));
        exp_b.push_back(model_phase(COEF_B, p));
      end
      rd_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    rst = 1'b1;
    drv_full = 1'b0;
    hold_empty = 1'b0;
    in_q.delete(); exp_a.delete(); exp_b.delete();
    got_a.delete(); got_b.delete(); rd_cyc.delete(); wr_cyc_a.delete();
    for (int i = 0; i < TAPS; i++) dl_m[i] = '0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_wrs(input int n, input string tag);
    int i;
    i = 0;
    while (wr_cyc_a.size() < n && i < TMO) begin
      @(posedge clk); #2;
      i++;
    end
    chk(tag, DW'(wr_cyc_a.size() >= n), DW'(1));
  endtask

  task automatic wait_rds(input int n, input string tag);
    int i;
    i = 0;
    while (rd_cyc.size() < n && i < TMO) begin
      @(posedge clk); #2;
      i++;
    end
    chk(tag, DW'(rd_cyc.size() >= n), DW'(1));
  endtask

  task automatic chk_seq(input string tag, input logic [DW-1:0] got[$], input int ev[8]);
    chk({tag, "_count"}, DW'(got.size()), DW'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 'x, DW'(ev[i] * GAIN));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int mac;
    for (int i = 0; i < TAPS; i++) dl_m[i] = '0;
    in_q.push_back(DW'(1024));
    in_q.push_back(DW'(0));
    repeat (3) @(posedge clk);
    #2;
    // Reset state with data waiting: nothing may pop or push.
    chk("rst_state", DW'(st_a), DW'(0));
    chk("rst_y_out", if_a.y_out, '0);
    chk("rst_y_wr_en", if_a.y_wr_en, 1'b0);
    chk("rst_x_rd_en_with_data", if_a.x_rd_en, 1'b0);
    rst = 1'b0;

    // Impulse through both instances, with timing.
    wait_wrs(8, "impulse_timeout");
    chk_seq("impulse_a", got_a, '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192});
    chk_seq("impulse_b", got_b, '{-3, -1, 102, 103, 104, 105, 106, 107});
    chk("lat_rd_to_wr", DW'(qat(wr_cyc_a, 0) - qat(rd_cyc, 0)), DW'(10));
    chk("phase_period", DW'(qat(wr_cyc_a, 1) - qat(wr_cyc_a, 0)), DW'(9));
    chk("sample_period", DW'(qat(rd_cyc, 1) - qat(rd_cyc, 0)), DW'(37));
    chk("lat_rd_to_wr_2", DW'(qat(wr_cyc_a, 4) - qat(rd_cyc, 1)), DW'(10));

    // Signed arithmetic and truncation toward zero.
    reset_dut();
    in_q.push_back(DW'(-1024));
    in_q.push_back(DW'(1));
    wait_wrs(8, "signed_timeout");
    chk_seq("signed_b", got_b, '{3, 1, -102, -103, -104, -105, -106, -107});

    // Backpressure held across phase 1.
    reset_dut();
    in_q.push_back(DW'(1024));
    in_q.push_back(DW'(0));
    wait_wrs(1, "bp_first_timeout");
    drv_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("bp_no_push", if_a.y_wr_en, 1'b0);
      chk("bp_y_out_stable", if_a.y_out, DW'(1024 * GAIN));
    end
    chk("bp_state_write", DW'(st_a), DW'(2));
    chk("bp_push_count", DW'(wr_cyc_a.size()), DW'(1));
    drv_full = 1'b0;
    wait_wrs(8, "bp_timeout");
    repeat (40) @(posedge clk);
    #2;
    chk_seq("bp_a", got_a, '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192});

    // Empty input FIFO: no activity, then normal cadence.
    reset_dut();
    hold_empty = 1'b1;
    in_q.push_back(DW'(1024));
    in_q.push_back(DW'(0));
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      chk("empty_no_rd", if_a.x_rd_en, 1'b0);
      chk("empty_no_wr", if_a.y_wr_en, 1'b0);
    end
    hold_empty = 1'b0;
    wait_rds(2, "empty_rd_timeout");
    wait_wrs(8, "empty_wr_timeout");
    chk("empty_sample_period", DW'(qat(rd_cyc, 1) - qat(rd_cyc, 0)), DW'(37));
    chk("empty_lat", DW'(qat(wr_cyc_a, 0) - qat(rd_cyc, 0)), DW'(10));
    chk_seq("empty_a", got_a, '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192});

    // Reset on the 5th MAC cycle of phase 1 discards everything in flight.
    reset_dut();
    in_q.push_back(DW'(1024));
    in_q.push_back(DW'(0));
    wait_wrs(1, "midrst_first_timeout");
    mac = 0;
    for (int i = 0; i < 40; i++) begin
      if (st_a == 2'd1) mac++;
      if (mac == 5) break;
      @(posedge clk); #2;
    end
    chk("midrst_reached_mac5", DW'(mac), DW'(5));
    chk("midrst_y_out_before", if_a.y_out, DW'(1024 * GAIN));
    rst = 1'b1;
    #1;
    chk("midrst_y_out", if_a.y_out, '0);
    chk("midrst_y_wr_en", if_a.y_wr_en, 1'b0);
    chk("midrst_state", DW'(st_a), DW'(0));
    chk("midrst_x_rd_en", if_a.x_rd_en, 1'b0);
    reset_dut();
    in_q.push_back(DW'(1024));
    in_q.push_back(DW'(0));
    wait_wrs(8, "midrst_timeout");
    chk_seq("midrst_a", got_a, '{1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192});

    // Random samples with random empty/full stalls, checked by the scoreboard.
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      int v;
      v = int'($urandom_range(0, 8191)) - 4096;
      in_q.push_back(DW'(v));
    end
    for (int i = 0; i < 6000 && wr_cyc_a.size() < 48; i++) begin
      drv_full   = ($urandom_range(0, 3) == 0);
      hold_empty = ($urandom_range(0, 5) == 0);
      @(posedge clk); #2;
    end
    drv_full = 1'b0;
    hold_empty = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("rand_push_count", DW'(wr_cyc_a.size()), DW'(48));
    chk("rand_exp_a_drained", DW'(exp_a.size()), DW'(0));
    chk("rand_exp_b_drained", DW'(exp_b.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
